pwl_logsig_eval: RTL and testbench
==================================

// Module: pwl_logsig_eval
// PURPOSE
//  Piecewise-linear logistic-sigmoid evaluator for the GRU gate datapath; consumer of segCoeffROM_logsig.
//  Takes a signed fixed-point pre-activation x and derives the segment address from |x|.
//  Reads the {A,B} coefficient word and computes y = A*|x| + B, then applies symmetry sigma(-x) = 1 - sigma(x).
//  Saturates outside the table range and streams results with valid/ready handshakes.
// PARAMETERS
//  NUM_COEFF_PAIRS  7   segments held in the coefficient ROM
//  ADDR_WL          $clog2(NUM_COEFF_PAIRS)   ROM address width
//  COEF_WL          8   width of A and of B: unsigned Q1.7; ROM word = {A[15:8], B[7:0]}
//  X_WI / X_WF      4/12   input format: signed Q4.12, 16 b
//  SEG_LOG2         0   segment width = 2^SEG_LOG2 in x units (1.0)
//  Y_WF             15  output: unsigned Q1.15, 16 b, range [0, 0x8000]
// PORTS
//  CLK          in   1         rising-edge clock
//  RST          in   1         reset, synchronous, active-high
//  in_valid     in   1         x_in valid
//  in_ready     out  1         block can accept x_in
//  x_in         in   16        signed Q4.12 pre-activation
//  rom_addr     out  ADDR_WL   segment index to coefficient ROM (registered)
//  rom_data     in   2*COEF_WL {A,B}; combinational ROM read of rom_addr, same cycle
//  out_valid    out  1         y_out valid
//  out_ready    in   1         downstream accepts y_out
//  y_out        out  16        unsigned Q1.15 sigmoid value
// BEHAVIOUR
//  - Pipeline: S1 captures |x|, sign, seg = |x| >> (X_WF+SEG_LOG2), sat = (seg >= NUM_COEFF_PAIRS); rom_addr = sat ? 0 : seg.
//  - S2: captures A, B from rom_data; computes P = A*|x| (Q5.19, 24 b unsigned).
//  - S3: computes Ypos = P + (B << 12) in Q.19. If sat, or Ypos > 2^19, then Ypos = 2^19 (1.0).
//  - S3: Yq = neg ? (2^19 - Ypos) : Ypos; y_out = Yq >> 4 (Q1.15); 0x8000 is the maximum.
//  - Latency: a transfer at edge N (in_valid & in_ready) gives out_valid at edge N+3 with no stall. Throughput is 1 sample/cycle.
//  - |x| of 0x8000 (-8.0) is 8.0, taken as unsigned 16 b; no overflow; saturates.
//  - Handshake: stall = out_valid & ~out_ready. Stall freezes all stages, rom_addr and y_out. in_ready = ~stall (combinational).
//  - Bubbles collapse: an empty stage advances even while later stages hold valid data. y_out/out_valid must not change while stalled.
//  - Samples leave in arrival order; none are dropped or duplicated.
//  - Reset: all stage valid bits = 0, out_valid = 0, y_out = 0, rom_addr = 0. in_ready = 1 in the cycle after RST is released.
//  - RST asserted mid-stream discards every in-flight sample; inputs presented while RST = 1 are ignored.
//  - RST overrides a simultaneous transfer. If out_ready falls in the same cycle out_valid rises, the result holds.
// CONFIGURATION
//  PWL_ROUND_EN defined:   S3 adds round-half-up: y_out = (Yq + 8) >> 4, clamped to 0x8000.
//  PWL_ROUND_EN undefined: y_out = Yq >> 4 (truncate). Latency and handshake are identical in both builds.
// TESTING
//  Uses the production 7-entry logsig ROM (seg0 A=0x1F B=0x40; seg1 A=0x1A B=0x44).
//  1. x=0x0000 -> rom_addr=0, y_out=0x4000 exactly 3 cycles after accept.
//  2. x=0x1800 (+1.5) -> rom_addr=1, y_out=0x6B00; x=0xE800 (-1.5) -> y_out=0x1500.
//  3. x=0x7800 (+7.5) -> y_out=0x8000; x=0x8000 (-8.0) -> y_out=0x0000.
//  4. x=0x0001 -> y_out=0x4001 without PWL_ROUND_EN, 0x4002 with PWL_ROUND_EN.
//  5. Stream 8 back-to-back samples; out_ready low for 5 cycles mid-stream.
//     -> in_ready low while stalled, y_out stable, all 8 results in order, no loss.
//  6. RST pulsed 1 cycle with 3 samples in flight -> out_valid=0 next cycle; those samples never appear; next sample has latency 3.

Source files
------------

// File: rtl/pwl_logsig_eval.sv
// Piecewise-linear logistic sigmoid: y = A*|x| + B per segment, mirrored for x < 0.
// Build option: define PWL_ROUND_EN for round-half-up output instead of truncation.
module pwl_logsig_eval #(
    parameter int NUM_COEFF_PAIRS = 7,
    parameter int ADDR_WL         = $clog2(NUM_COEFF_PAIRS),
    parameter int COEF_WL         = 8,
    parameter int X_WI            = 4,
    parameter int X_WF            = 12,
    parameter int SEG_LOG2        = 0,
    parameter int Y_WF            = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_WI+X_WF-1:0]   x_in,
    output logic [ADDR_WL-1:0]     rom_addr,
    input  logic [2*COEF_WL-1:0]   rom_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Y_WF:0]          y_out
);

    localparam int XW = X_WI + X_WF;
    localparam int PW = COEF_WL + XW;
    localparam int FW = COEF_WL - 1 + X_WF;
    localparam int SH = FW - Y_WF;

    localparam logic [PW:0]   ONE_S = (PW+1)'(1) << FW;
    localparam logic [FW:0]   ONE_Y = (FW+1)'(1) << FW;
    localparam logic [Y_WF:0] ONE_O = (Y_WF+1)'(1) << Y_WF;

    logic                 stall;
    logic                 acc;
    logic                 en1, en2, en3, en_o;

    logic [XW-1:0]        absx_d;
    logic [XW-1:0]        seg_d;
    logic                 sat_d;
    logic [ADDR_WL-1:0]   addr_d;
    logic [PW-1:0]        prod_d;
    logic [PW:0]          ysum_d;
    logic [FW:0]          ypos_d;
    logic [FW:0]          yq_d;
    logic [Y_WF:0]        y_d;

    logic                 v1_q, v2_q, v3_q;
    logic [XW-1:0]        absx1_q;
    logic                 neg1_q, sat1_q;
    logic [ADDR_WL-1:0]   rom_addr_q;
    logic [PW-1:0]        p2_q;
    logic [COEF_WL-1:0]   b2_q;
    logic                 neg2_q, sat2_q;
    logic [FW:0]          ypos3_q;
    logic                 neg3_q;
    logic                 out_valid_q;
    logic [Y_WF:0]        y_q;

`ifdef PWL_ROUND_EN
    logic [FW+1:0]        yr_d;
`endif

    // A stage moves when it is empty or its successor moves, so bubbles collapse.
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;
    assign acc      = in_valid & in_ready;
    assign en_o     = ~stall;
    assign en3      = ~v3_q | en_o;
    assign en2      = ~v2_q | en3;
    assign en1      = ~v1_q | en2;

    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;

    always_comb begin
        absx_d = x_in[XW-1] ? (~x_in + XW'(1)) : x_in;
        seg_d  = absx_d >> (X_WF + SEG_LOG2);
        sat_d  = seg_d >= XW'(NUM_COEFF_PAIRS);
        addr_d = sat_d ? '0 : seg_d[ADDR_WL-1:0];
        prod_d = PW'(rom_data[2*COEF_WL-1:COEF_WL]) * PW'(absx1_q);
        ysum_d = (PW+1)'(p2_q) + ((PW+1)'(b2_q) << X_WF);
        ypos_d = (sat2_q || ysum_d > ONE_S) ? ONE_Y : ysum_d[FW:0];
        yq_d   = neg3_q ? (ONE_Y - ypos3_q) : ypos3_q;
`ifdef PWL_ROUND_EN
        yr_d = ({1'b0, yq_d} + (FW+2)'(1 << (SH-1))) >> SH;
        y_d  = (yr_d > (FW+2)'(ONE_O)) ? ONE_O : yr_d[Y_WF:0];
`else
        y_d  = (Y_WF+1)'(yq_d >> SH);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            absx1_q     <= '0;
            neg1_q      <= 1'b0;
            sat1_q      <= 1'b0;
            rom_addr_q  <= '0;
            p2_q        <= '0;
            b2_q        <= '0;
            neg2_q      <= 1'b0;
            sat2_q      <= 1'b0;
            ypos3_q     <= '0;
            neg3_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            if (en1) begin
                v1_q <= acc;
                if (acc) begin
                    absx1_q    <= absx_d;
                    neg1_q     <= x_in[XW-1];
                    sat1_q     <= sat_d;
                    rom_addr_q <= addr_d;
                end
            end
            if (en2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    p2_q   <= prod_d;
                    b2_q   <= rom_data[COEF_WL-1:0];
                    neg2_q <= neg1_q;
                    sat2_q <= sat1_q;
                end
            end
            if (en3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    ypos3_q <= ypos_d;
                    neg3_q  <= neg2_q;
                end
            end
            if (en_o) begin
                out_valid_q <= v3_q;
                if (v3_q) y_q <= y_d;
            end
        end
    end

endmodule

// File: tb/tb_pwl_logsig_eval.sv
// Bench for pwl_logsig_eval: directed spec points, stall/reset cases, random stream.
module tb_pwl_logsig_eval;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_out;

    logic [15:0] rom [8];

    typedef struct {
        logic [15:0] y;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_pop = 0;
    bit          lat_on;
    bit          hold = 0;
    bit          acc_fl;
    logic [15:0] hold_y;

    always #5 CLK = ~CLK;

    assign rom_data = rom[rom_addr];

    pwl_logsig_eval dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out)
    );

    function automatic int seg_of(logic [15:0] x);
        int ax;
        ax = x[15] ? 65536 - int'(x) : int'(x);
        return ax / 4096;
    endfunction

    function automatic int exp_addr(logic [15:0] x);
        int s;
        s = seg_of(x);
        return (s >= 7) ? 0 : s;
    endfunction

    function automatic logic [15:0] ref_y(logic [15:0] x);
        int ax, s, yp, yq, y;
        ax = x[15] ? 65536 - int'(x) : int'(x);
        s  = ax / 4096;
        if (s >= 7) yp = 524288;
        else begin
            yp = int'(rom[s][15:8]) * ax + int'(rom[s][7:0]) * 4096;
            if (yp > 524288) yp = 524288;
        end
        yq = x[15] ? 524288 - yp : yp;
`ifdef PWL_ROUND_EN
        y = (yq + 8) / 16;
        if (y > 32768) y = 32768;
`else
        y = yq / 16;
`endif
        return 16'(y);
    endfunction

    task automatic check(string tag, int obs, int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge CLK);
        acc_fl = 1'b0;
        if (hold) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_y", int'(y_out), int'(hold_y));
            hold = 1'b0;
        end
        if (RST) q.delete();
        else begin
            if (out_valid && !out_ready) begin
                check("in_ready_stall", int'(in_ready), 0);
                hold   = 1'b1;
                hold_y = y_out;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    e = q.pop_front();
                    check("y_out", int'(y_out), int'(e.y));
                    if (lat_on) check("latency", cyc - e.cyc, 4);
                    n_pop++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{ref_y(x_in), cyc});
                acc_fl = 1'b1;
            end
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(logic [15:0] x);
        in_valid = 1'b1;
        x_in     = x;
        step();
        in_valid = 1'b0;
        check("accept", int'(acc_fl), 1);
        check("rom_addr", int'(rom_addr), exp_addr(x));
        repeat (5) step();
        check("drained", q.size(), 0);
    endtask

    function automatic logic [15:0] rand_x();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 16'h1FFF));
            2:       return 16'(-$urandom_range(0, 16'h1FFF));
            default: return 16'($urandom_range(16'h5000, 16'h7FFF));
        endcase
    endfunction

    initial begin
        int sent, p0;
        bit newx;
        rom[0] = 16'h1F40; rom[1] = 16'h1A44; rom[2] = 16'h1250;
        rom[3] = 16'h0A60; rom[4] = 16'h056C; rom[5] = 16'h0274;
        rom[6] = 16'h0178; rom[7] = 16'h0000;
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
        lat_on = 1'b1;
        repeat (3) step();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y_out", int'(y_out), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        RST = 1'b0;
        step();
        check("rst_in_ready", int'(in_ready), 1);

        send(16'h0000);
        send(16'h1800);
        send(16'hE800);
        send(16'h7800);
        send(16'h8000);
        send(16'h0001);
        send(16'h7000);
        send(16'hF000);

        // back-to-back stream with a 5-cycle downstream stall
        lat_on = 1'b0;
        sent = 0; newx = 1'b1; p0 = n_pop;
        for (int i = 0; i < 40; i++) begin
            in_valid = (sent < 8);
            if (in_valid && newx) begin
                x_in = rand_x();
                newx = 1'b0;
            end
            out_ready = !(i >= 6 && i < 11);
            step();
            if (acc_fl) begin
                sent++;
                newx = 1'b1;
            end
        end
        in_valid = 1'b0;
        check("stream_count", n_pop - p0, 8);
        check("stream_q", q.size(), 0);

        // reset with three samples in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x_in     = rand_x();
            step();
        end
        RST = 1'b1;
        x_in = 16'h1234;
        step();
        RST = 1'b0;
        in_valid = 1'b0;
        check("rst_flush_valid", int'(out_valid), 0);
        check("rst_flush_ready", int'(in_ready), 1);
        repeat (6) step();
        lat_on = 1'b1;
        send(16'h1800);

        // random traffic with random backpressure
        lat_on = 1'b0;
        newx = 1'b1;
        p0 = n_pop;
        sent = 0;
        for (int i = 0; i < 600; i++) begin
            if (newx) begin
                in_valid = ($urandom_range(0, 3) != 0);
                x_in     = rand_x();
                newx     = !in_valid;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc_fl) begin
                sent++;
                newx = 1'b1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        check("rand_count", n_pop - p0, sent);
        check("rand_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
